// File: rtl/shot_arbiter.sv
// shot_arbiter: shares one submarine engine between two players.
// Ports: clk, rstn (async low); p0/p1 req/x/y in, p0/p1 ack out;
//   eng_cord_valid/eng_x/eng_y out, eng_busy/hit/sink/done in;
//   resp_valid/player/hit/sink/reject out; turn, p0/p1_sinks,
//   game_over, winner, err_timeout out.
// Optional macro DUP_FILTER_EN: per-player duplicate shot filter.
module shot_arbiter #(
  parameter int WIDTH        = 6,
  parameter int STRICT_TURNS = 1,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       p0_req,
  input  logic       p1_req,
  input  logic [2:0] p0_x,
  input  logic [2:0] p0_y,
  input  logic [2:0] p1_x,
  input  logic [2:0] p1_y,
  output logic       p0_ack,
  output logic       p1_ack,
  output logic       eng_cord_valid,
  output logic [2:0] eng_x,
  output logic [2:0] eng_y,
  input  logic       eng_busy,
  input  logic       eng_hit,
  input  logic       eng_sink,
  input  logic       eng_done,
  output logic       resp_valid,
  output logic       resp_player,
  output logic       resp_hit,
  output logic       resp_sink,
  output logic       resp_reject,
  output logic       turn,
  output logic [2:0] p0_sinks,
  output logic [2:0] p1_sinks,
  output logic       game_over,
  output logic       winner,
  output logic       err_timeout
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [3:0] WLIM = 4'(WIDTH);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, REPORT, OVER
  } st_t;

  st_t st_q;
  logic          ack0_q, ack1_q;
  logic          cv_q;
  logic [2:0]    ex_q, ey_q;
  logic          rv_q, rp_q, rh_q, rs_q, rr_q;
  logic          turn_q;
  logic [2:0]    s0_q, s1_q;
  logic          over_q, win_q, tmo_q;
  logic          gp_q, done_q;
  logic [TW-1:0] cnt_q;

  logic       r0, r1, t_req, o_req, rr_en;
  logic       grant, gsel, legal, dup, reject;
  logic [2:0] gx, gy;
  logic       inc0, inc1, win_d;
  logic [2:0] s0_d, s1_d;
  logic       leave, tmo_hit;

  // A request is masked while its ack is visible: the player
  // only drops req after seeing the ack.
  assign r0    = p0_req & ~ack0_q;
  assign r1    = p1_req & ~ack1_q;
  assign t_req = turn_q ? r1 : r0;
  assign o_req = turn_q ? r0 : r1;
  assign rr_en = (STRICT_TURNS == 0);
  assign grant = t_req | (rr_en & o_req);
  assign gsel  = t_req ? turn_q : ~turn_q;
  assign gx    = gsel ? p1_x : p0_x;
  assign gy    = gsel ? p1_y : p0_y;
  assign legal = ({1'b0, gx} < WLIM) & ({1'b0, gy} < WLIM);

`ifdef DUP_FILTER_EN
  localparam int CELLS = WIDTH * WIDTH;
  localparam int IW    = $clog2(CELLS);
  logic [CELLS-1:0] map0_q, map1_q;
  logic [IW-1:0]    idx;
  assign idx = IW'(gx) * IW'(WIDTH) + IW'(gy);
  assign dup = legal & (gsel ? map1_q[idx] : map0_q[idx]);
`else
  assign dup = 1'b0;
`endif

  assign reject = ~legal | dup;

  assign inc0  = eng_sink & ~gp_q & (s0_q != 3'd7);
  assign inc1  = eng_sink & gp_q & (s1_q != 3'd7);
  assign s0_d  = s0_q + {2'b00, inc0};
  assign s1_d  = s1_q + {2'b00, inc1};
  // Tie goes to the player who fired the final shot.
  assign win_d = (s1_d > s0_d) | ((s1_d == s0_d) & gp_q);

  assign leave   = (st_q == WAIT_DONE) & ~eng_busy;
  assign tmo_hit = (cnt_q == TW'(RESP_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= IDLE;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      cv_q   <= 1'b0;
      ex_q   <= '0;
      ey_q   <= '0;
      rv_q   <= 1'b0;
      rp_q   <= 1'b0;
      rh_q   <= 1'b0;
      rs_q   <= 1'b0;
      rr_q   <= 1'b0;
      turn_q <= 1'b0;
      s0_q   <= '0;
      s1_q   <= '0;
      over_q <= 1'b0;
      win_q  <= 1'b0;
      tmo_q  <= 1'b0;
      gp_q   <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
`ifdef DUP_FILTER_EN
      map0_q <= '0;
      map1_q <= '0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      cv_q   <= 1'b0;
      rv_q   <= 1'b0;
      rh_q   <= 1'b0;
      rs_q   <= 1'b0;
      rr_q   <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (grant) begin
            ack0_q <= ~gsel;
            ack1_q <= gsel;
            if (reject) begin
              rv_q <= 1'b1;
              rr_q <= 1'b1;
              rp_q <= gsel;
            end else begin
              ex_q <= gx;
              ey_q <= gy;
              gp_q <= gsel;
              st_q <= ISSUE;
`ifdef DUP_FILTER_EN
              if (gsel) map1_q[idx] <= 1'b1;
              else      map0_q[idx] <= 1'b1;
`endif
            end
          end
        end
        ISSUE: begin
          if (!eng_busy) begin
            cv_q  <= 1'b1;
            cnt_q <= '0;
            st_q  <= WAIT_BUSY;
          end
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (leave) begin
            rv_q   <= 1'b1;
            rp_q   <= gp_q;
            rh_q   <= eng_hit;
            rs_q   <= eng_sink;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            turn_q <= ~gp_q;
            done_q <= eng_done;
            if (eng_done) begin
              over_q <= 1'b1;
              win_q  <= win_d;
            end
            st_q <= REPORT;
          end else if (tmo_hit) begin
            tmo_q  <= 1'b1;
            over_q <= 1'b1;
            st_q   <= OVER;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (st_q == WAIT_BUSY && eng_busy)
              st_q <= WAIT_DONE;
          end
        end
        REPORT: st_q <= done_q ? OVER : IDLE;
        OVER:   st_q <= OVER;
        default: st_q <= IDLE;
      endcase
    end
  end

  assign p0_ack         = ack0_q;
  assign p1_ack         = ack1_q;
  assign eng_cord_valid = cv_q;
  assign eng_x          = ex_q;
  assign eng_y          = ey_q;
  assign resp_valid     = rv_q;
  assign resp_player    = rp_q;
  assign resp_hit       = rh_q;
  assign resp_sink      = rs_q;
  assign resp_reject    = rr_q;
  assign turn           = turn_q;
  assign p0_sinks       = s0_q;
  assign p1_sinks       = s1_q;
  assign game_over      = over_q;
  assign winner         = win_q;
  assign err_timeout    = tmo_q;

endmodule

// File: doc/shot_arbiter.md
Name: shot_arbiter

Overview:
- Shares one submarine game engine (the submarine_top coordinate/hit/sink datapath) between two players.
- Applies the turn policy, optionally rejects duplicate and out-of-range shots, and issues at most one engine shot at a time.
- Returns each per-shot result to the player who fired, keeps per-player sink scores and declares a winner when the engine asserts done.

Parameters:
- WIDTH, 6: grid dimension; a coordinate is legal when x < WIDTH and y < WIDTH.
- STRICT_TURNS, 1: 1 = strict alternation; 0 = work-conserving round-robin (the idle turn-holder is skipped).
- RESP_TIMEOUT, 64: maximum cycles to wait for the engine result before raising an error.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- p0_req, p1_req  in  1  player shot request; held until the matching ack.
- p0_x, p0_y, p1_x, p1_y  in  3  player shot coordinate; stable while req is high.
- p0_ack, p1_ack  out  1  one-cycle pulse: request consumed (forwarded or rejected).
- eng_cord_valid  out  1  one-cycle shot strobe to the engine.
- eng_x, eng_y  out  3  coordinate to the engine; held from issue until the result.
- eng_busy, eng_hit, eng_sink, eng_done  in  1  engine status.
- resp_valid  out  1  one-cycle result pulse.
- resp_player  out  1  player the result belongs to.
- resp_hit, resp_sink, resp_reject  out  1  result flags; valid only while resp_valid is high.
- turn  out  1  player holding the turn.
- p0_sinks, p1_sinks  out  3  sink count per player, saturating at 7.
- game_over  out  1  sticky; set when the game ends.
- winner  out  1  valid while game_over is high.
- err_timeout  out  1  sticky engine-timeout error.

Behaviour:
- Reset (async, rstn=0): all outputs 0, turn=0, shot maps cleared, state IDLE. Reset mid-shot abandons the shot silently.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, REPORT, OVER.
- IDLE, player selection:
  - Grant the turn-holder if it requests.
  - Otherwise, with STRICT_TURNS=0, grant the other player if it requests.
  - Otherwise stay in IDLE.
- IDLE, grant handling:
  - Illegal coordinate, or duplicate (when the filter is compiled in): ack the player, drive resp_valid with resp_reject=1 in the same cycle, leave turn unchanged, stay in IDLE.
  - Legal shot: ack the player, latch the coordinate into eng_x/eng_y, go to ISSUE.
- ISSUE: wait for eng_busy=0, then pulse eng_cord_valid for one cycle and go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE on eng_busy=1.
- WAIT_DONE: on the first cycle eng_busy=0, sample eng_hit/eng_sink/eng_done and go to REPORT.
- Timeout: a single counter covers WAIT_BUSY and WAIT_DONE together. When it reaches RESP_TIMEOUT, set err_timeout and game_over, then go to OVER.
- REPORT, lasting one cycle:
  - resp_valid=1 with the sampled flags; resp_player = the granted player.
  - On sink, increment that player's sinks (saturating).
  - Toggle turn to the other player. A hit does not grant an extra shot.
  - If done was sampled: game_over=1, go to OVER. Otherwise go to IDLE.
- Winner: the player with more sinks; on a tie, the player who fired the final shot.
- OVER: absorbing until reset. Requests get no ack, and eng_cord_valid stays 0.
- Simultaneous p0_req and p1_req: only the selected player is acked. The other keeps req high and is served on its turn.
- eng_done rising outside WAIT_DONE is ignored; done is sampled only together with a result.
- Throughput: at most one outstanding shot. Minimum of 5 cycles from request to resp_valid with a 1-cycle engine.

Optional Feature:
- DUP_FILTER_EN defined:
  - Each player has a WIDTH*WIDTH-bit shot map, indexed x*WIDTH+y and set on issue.
  - A repeat shot by the same player is rejected without engine access.
  - The two maps are independent.
- DUP_FILTER_EN undefined:
  - No maps are built; duplicates are forwarded to the engine.
  - resp_reject is raised for illegal coordinates only.

Test Plan:
- Reset, then p0 fires (1,2) against an engine that returns hit=1, sink=0 → eng_x=1, eng_y=2, eng_cord_valid single pulse; resp_valid with player=0, hit=1; turn becomes 1.
- Both players request every cycle with STRICT_TURNS=1 → engine sequence strictly alternates p0, p1, p0, p1; each ack is a single pulse.
- p1 idle, p0 requesting, STRICT_TURNS=0 → p0 is served back-to-back. With STRICT_TURNS=1 → p0 stalls and gets no ack.
- DUP_FILTER_EN defined: p0 shoots (3,3) twice; separately p0 shoots (6,0) → second (3,3) and (6,0) both give resp_reject=1 in the ack cycle, no eng_cord_valid, turn unchanged.
- Engine holds busy=1 for RESP_TIMEOUT cycles → err_timeout=1, game_over=1; later requests get no ack.
- Game ends with p0_sinks=2, p1_sinks=2 and the final sink+done from p1 → game_over=1, winner=1. Asserting rstn=0 mid-WAIT_DONE clears all outputs immediately.
